feature_loader: RTL and testbench
=================================

// Module: feature_loader
// PURPOSE
//  Write-side master for the feature weight memory.
//  - Accepts a serial stream of 2-bit signed kernel weights over a valid/ready handshake.
//  - Packs each group of KERNEL_SIZE*KERNEL_SIZE weights into one kernel.
//  - Writes each kernel into the memory's write port: address, active-low write enable, weight vector.
//  - Sits between the off-chip/config input path and the weight memory; runs once per model load.
// PARAMETERS
//  KERNEL_SIZE   3   kernel side length; KK = KERNEL_SIZE*KERNEL_SIZE weights per feature
//  NUM_FEATURES 10   number of feature kernels loaded per start
// PORTS
//  clk           in   1                       chip clock, all state on posedge
//  rst           in   1                       synchronous, active-low reset
//  start         in   1                       begin a load; sampled only in IDLE
//  abort         in   1                       cancel load, return to IDLE
//  in_valid      in   1                       in_weight is valid
//  in_weight     in   2 signed                next weight, row-major within kernel
//  in_ready      out  1                       loader can accept a weight this cycle
//  address_w     out  $clog2(NUM_FEATURES)+1  feature index being written
//  feature_WrEn  out  1                       write enable to weight memory, active low
//  weights_input out  2 signed x KK           packed kernel, [r*KERNEL_SIZE+c]
//  busy          out  1                       high in COLLECT/WRITE/DONE
//  done          out  1                       one-cycle pulse after last kernel written
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//   - State = IDLE; counters and buffer cleared.
//   - Outputs: in_ready=0, feature_WrEn=1, address_w=0, weights_input all 0, busy=0, done=0.
//  Output timing:
//   - All outputs are decoded from registered state/counters; no combinational path from any input.
//   - The memory samples on negedge clk, so a write asserted in cycle N lands mid-cycle N.
//  FSM states: IDLE -> COLLECT -> WRITE -> (COLLECT | DONE) -> IDLE.
//   - IDLE: in_ready=0. start==1 -> COLLECT with feat_cnt=0, w_cnt=0.
//   - COLLECT: in_ready=1. When in_valid&in_ready, buffer[w_cnt]<=in_weight and w_cnt++.
//     Beat with w_cnt==KK-1 -> WRITE.
//     in_valid low stalls: nothing changes, no timeout.
//   - WRITE (exactly 1 cycle): in_ready=0, feature_WrEn=0, address_w=feat_cnt,
//     weights_input=buffer.
//     feat_cnt==NUM_FEATURES-1 -> DONE; else feat_cnt++, w_cnt=0 -> COLLECT.
//   - DONE (1 cycle): done=1, feature_WrEn=1 -> IDLE.
//  feature_WrEn rules:
//   - Low only in WRITE; exactly NUM_FEATURES low cycles per completed load.
//   - address_w is always < NUM_FEATURES while low.
//  address_w and weights_input:
//   - Hold their last value outside WRITE.
//   - Weights are passed unmodified; -2 (2'b10) is legal, with no saturation or remapping.
//  Latency:
//   - start sampled at cycle 0 -> first beat accepted at cycle 1.
//   - With continuous in_valid, kernel n is written at cycle (n+1)*(KK+1).
//   - done at cycle NUM_FEATURES*(KK+1)+1.
//  Boundaries:
//   - start while busy: ignored.
//   - start and abort together in IDLE: abort wins, stay IDLE.
//   - abort in any state, including WRITE: next cycle IDLE, feature_WrEn=1, counters zeroed,
//     no done.
//     Kernels already written stay in memory; the partially collected kernel is discarded.
//   - Reset mid-load behaves as abort and also clears the outputs.
//   - Beats offered in IDLE/WRITE/DONE are not accepted (in_ready=0); the source must hold them.
// TESTING
//  1. Reset: rst=0 for 2 cycles with in_valid=1 -> feature_WrEn=1, in_ready=0, busy=0, done=0,
//     weights_input all 0.
//  2. Full load, continuous valid, weights for feature f elem e = ((f+e)%4)-2:
//     -> 10 WrEn-low cycles at cycles 10,20..100, address 0..9, matching vectors;
//     done at cycle 101 only.
//  3. Backpressure: deassert in_valid every other cycle during feature 0
//     -> write at cycle 19, vector unchanged, no dropped or duplicated beats.
//  4. Abort after 4 beats of feature 3 -> next cycle IDLE, no further WrEn-low, no done;
//     a new start reloads from address 0.
//  5. start pulsed while in COLLECT at feature 5 -> ignored; load completes with exactly
//     10 writes.
//  6. Reset asserted on a WRITE cycle -> next cycle feature_WrEn=1, all outputs at reset values.

Source files
------------

// File: rtl/feature_loader.sv
// feature_loader: packs a serial 2-bit weight stream into kernels and writes them to the weight memory
module feature_loader #(
  parameter int KERNEL_SIZE = 3,
  parameter int NUM_FEATURES = 10,
  localparam int KK = KERNEL_SIZE * KERNEL_SIZE,
  localparam int AW = $clog2(NUM_FEATURES) + 1,
  localparam int WW = $clog2(KK)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                in_valid,
  input  logic [1:0]          in_weight,
  output logic                in_ready,
  output logic [AW-1:0]       address_w,
  output logic                feature_WrEn,
  output logic [KK-1:0][1:0]  weights_input,
  output logic                busy,
  output logic                done
);
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [AW-1:0] feat_cnt, addr_q;
  logic [WW-1:0] w_cnt;
  logic [KK-1:0][1:0] buffer, wts_q;
  logic beat, last_w, last_f;
  always_comb begin
    in_ready = state == COLLECT;
    feature_WrEn = state != WRITE;
    busy = state != IDLE;
    done = state == DONE;
    address_w = state == WRITE ? feat_cnt : addr_q;
    weights_input = state == WRITE ? buffer : wts_q;
    beat = in_valid && in_ready;
    last_w = w_cnt == WW'(KK - 1);
    last_f = feat_cnt == AW'(NUM_FEATURES - 1);
    state_n = state;
    case (state)
      IDLE:    state_n = start ? COLLECT : IDLE;
      COLLECT: state_n = (beat && last_w) ? WRITE : COLLECT;
      WRITE:   state_n = last_f ? DONE : COLLECT;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  // The write in WRITE has already happened even if abort arrives, so the held outputs still capture it
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      feat_cnt <= '0;
      w_cnt <= '0;
      buffer <= '0;
      addr_q <= '0;
      wts_q <= '0;
    end else begin
      state <= state_n;
      if (beat) begin
        buffer[w_cnt] <= in_weight;
        w_cnt <= w_cnt + 1'b1;
      end
      if (state == WRITE) begin
        addr_q <= feat_cnt;
        wts_q <= buffer;
        feat_cnt <= last_f ? feat_cnt : feat_cnt + 1'b1;
        w_cnt <= '0;
      end
      if ((state == IDLE && start) || abort) begin
        feat_cnt <= '0;
        w_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_feature_loader.sv
// tb_feature_loader: directed checks of load timing, backpressure, abort, start-while-busy and reset
module tb_feature_loader;
  logic clk = 0;
  logic rst, start, abort, in_valid;
  logic [1:0] in_weight;
  logic in_ready, feature_WrEn, busy, done;
  logic [4:0] address_w;
  logic [8:0][1:0] weights_input;
  int n_chk = 0, n_fail = 0, cyc = 0, s0 = 0;
  bit src_en = 1, bp = 0;
  logic [1:0] src_q[$];
  int wr_a[$], wr_c[$], done_c[$];
  logic [17:0] wr_v[$];

  feature_loader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
    .in_weight(in_weight), .in_ready(in_ready), .address_w(address_w),
    .feature_WrEn(feature_WrEn), .weights_input(weights_input), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // source: presents the queue head, pops only on an accepted beat
  always begin
    @(negedge clk);
    in_valid = src_en && src_q.size() > 0 && !(bp && (cyc - s0) < 19 && (cyc - s0) % 2 == 1);
    in_weight = src_q.size() > 0 ? src_q[0] : 2'b00;
    #4;
    if (in_valid && in_ready) void'(src_q.pop_front());
  end

  always @(negedge clk) begin
    if (!feature_WrEn) begin
      wr_a.push_back(int'(address_w));
      wr_v.push_back(weights_input);
      wr_c.push_back(cyc - s0);
    end
    if (done) done_c.push_back(cyc - s0);
  end

  function automatic logic [17:0] kv(int f);
    logic [17:0] v;
    for (int e = 0; e < 9; e++) begin
      int x;
      x = ((f + e) % 4) - 2;
      v[e*2 +: 2] = x[1:0];
    end
    return v;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_load();
    for (int f = 0; f < 10; f++) begin
      logic [17:0] v;
      v = kv(f);
      for (int e = 0; e < 9; e++) src_q.push_back(v[e*2 +: 2]);
    end
    @(negedge clk);
    wr_a.delete(); wr_v.delete(); wr_c.delete(); done_c.delete();
    start = 1;
    s0 = cyc;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && done_c.size() == 0; i++) @(negedge clk);
    check("done_timeout", done_c.size() > 0, 1);
    @(negedge clk);
  endtask

  task automatic check_writes(string tag, bit timed);
    check({tag, "_nwr"}, wr_a.size(), 10);
    for (int i = 0; i < 10 && i < wr_a.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_a[i], i);
      check($sformatf("%s_vec%0d", tag, i), wr_v[i], kv(i));
      if (timed) check($sformatf("%s_cyc%0d", tag, i), wr_c[i], 10 * (i + 1));
    end
  endtask

  initial begin
    rst = 0; start = 0; abort = 0;
    src_q.push_back(2'b01);
    repeat (2) @(negedge clk);
    check("rst_wren", feature_WrEn, 1);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wts", weights_input, 0);
    check("rst_addr", address_w, 0);
    rst = 1;
    src_q.delete();

    start_load();
    wait_done();
    check_writes("full", 1);
    check("full_ndone", done_c.size(), 1);
    if (done_c.size() > 0) check("full_done_cyc", done_c[0], 101);
    check("full_src_left", src_q.size(), 0);

    bp = 1;
    start_load();
    wait_done();
    bp = 0;
    check_writes("bp", 0);
    if (wr_c.size() > 0) check("bp_first_cyc", wr_c[0], 19);
    check("bp_src_left", src_q.size(), 0);

    start_load();
    repeat (34) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("ab_busy", busy, 0);
    check("ab_ready", in_ready, 0);
    check("ab_wren", feature_WrEn, 1);
    check("ab_addr_hold", address_w, 2);
    check("ab_wts_hold", weights_input, kv(2));
    repeat (20) @(negedge clk);
    check("ab_nwr", wr_a.size(), 3);
    check("ab_ndone", done_c.size(), 0);
    src_q.delete();
    start_load();
    wait_done();
    check_writes("reload", 1);

    start_load();
    repeat (53) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done();
    check_writes("sbusy", 1);
    check("sbusy_ndone", done_c.size(), 1);
    if (done_c.size() > 0) check("sbusy_done_cyc", done_c[0], 101);

    start_load();
    repeat (9) @(negedge clk);
    check("wr_before_rst", feature_WrEn, 0);
    rst = 0;
    @(negedge clk);
    rst = 1;
    check("mrst_wren", feature_WrEn, 1);
    check("mrst_addr", address_w, 0);
    check("mrst_wts", weights_input, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_ready", in_ready, 0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
